// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch stage.
// Rev 1.0
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_MISS    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALTED  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [4:0]  HALT_OPCODE   = 5'b00000;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction/PC holding buffer used while the PC is stalled.
// Rev 1.0
`default_nettype none

module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] instr_d,
  input  logic [15:0] pc_d,
  output logic        full,
  output logic [15:0] instr_q,
  output logic [15:0] pc_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 1'b0;
      instr_q <= 16'h0000;
      pc_q    <= 16'h0000;
    end else if (clear) begin
      full    <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-fetch stage feeding IF/ID (redirect, stall, miss, halt).
// Optional FETCH_BUF_EN: holds a completed fetch during PC_stall instead of re-reading. Rev 1.0
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_PC,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] IF_instr,
  output logic [15:0] IF_PC_2,
  output logic        IF_HALT,
  output logic        IF_valid
);

  fetch_state_t state, state_nxt;
  logic [15:0]  pc, pc_nxt, pc_plus2;
  logic         buf_full, buf_load, buf_clear;
  logic [15:0]  buf_instr, buf_pc;

  assign pc_plus2 = pc + 16'd2;

`ifdef FETCH_BUF_EN
  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .instr_d (imem_data),
    .pc_d    (pc),
    .full    (buf_full),
    .instr_q (buf_instr),
    .pc_q    (buf_pc)
  );
`else
  logic buf_unused;
  assign buf_full   = 1'b0;
  assign buf_instr  = NOP_INSTR;
  assign buf_pc     = pc;
  assign buf_unused = buf_load | buf_clear;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Outputs stay at their idle defaults while reset is held.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    imem_rd   = 1'b0;
    imem_addr = pc;
    IF_valid  = 1'b0;
    IF_instr  = NOP_INSTR;
    IF_PC_2   = pc_plus2;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH, S_MISS: begin
          if (buf_full) begin
            IF_valid = 1'b1;
            IF_instr = buf_instr;
            IF_PC_2  = buf_pc + 16'd2;
            if (redirect) begin
              IF_valid  = 1'b0;
              IF_instr  = NOP_INSTR;
              buf_clear = 1'b1;
              pc_nxt    = redirect_PC;
              state_nxt = S_FETCH;
            end else if (!PC_stall) begin
              buf_clear = 1'b1;
              pc_nxt    = pc_plus2;
              state_nxt = is_halt(buf_instr) ? S_HALTED : S_FETCH;
            end
          end else begin
            imem_rd = 1'b1;
            if (redirect) begin
              // Data completing alongside the redirect is dropped; only an
              // access still in flight needs waiting out.
              pc_nxt    = redirect_PC;
              state_nxt = (state == S_MISS && !imem_done) ? S_DISCARD : S_FETCH;
            end else if (imem_done) begin
              IF_valid  = 1'b1;
              IF_instr  = imem_data;
              state_nxt = S_FETCH;
              if (PC_stall) begin
                buf_load = 1'b1;
              end else begin
                pc_nxt = pc_plus2;
                if (is_halt(imem_data)) state_nxt = S_HALTED;
              end
            end else if (imem_stall) begin
              state_nxt = S_MISS;
            end
          end
        end
        S_DISCARD: begin
          if (redirect) pc_nxt = redirect_PC;
          if (imem_done) state_nxt = S_FETCH;
        end
        S_HALTED: begin
          if (redirect) begin
            pc_nxt    = redirect_PC;
            state_nxt = S_FETCH;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign IF_HALT = IF_valid && is_halt(IF_instr);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard checked by an independent monitor.
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_stall, redirect;
  logic [15:0] redirect_PC;
  logic [15:0] imem_addr, imem_data;
  logic        imem_rd, imem_stall, imem_done;
  logic [15:0] IF_instr, IF_PC_2;
  logic        IF_HALT, IF_valid;

  logic        m_auto, m_done, m_stall;
  logic [15:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        halt;
  } exp_t;
  exp_t sb_q[$];

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .PC_stall(PC_stall), .redirect(redirect),
    .redirect_PC(redirect_PC), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_stall(imem_stall), .imem_done(imem_done),
    .IF_instr(IF_instr), .IF_PC_2(IF_PC_2), .IF_HALT(IF_HALT), .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4001;
      16'h0002: return 16'h4002;
      16'h0004: return 16'h4003;
      16'h0006: return 16'h0800;
      16'h0008: return 16'h0000;
      16'h0020: return 16'h4020;
      16'h0100: return 16'h4100;
      16'hFFFE: return 16'h4FFE;
      default:  return 16'h1234;
    endcase
  endfunction

  // Memory: single-cycle hit in auto mode, otherwise driven directly by the stimulus.
  always_comb begin
    if (m_auto) begin
      imem_done  = imem_rd;
      imem_stall = 1'b0;
      imem_data  = mem_word(imem_addr);
    end else begin
      imem_done  = m_done;
      imem_stall = m_stall;
      imem_data  = m_data;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid presentation must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && IF_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr %h pc2 %h expected no valid output", IF_instr, IF_PC_2);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (IF_instr !== e.instr || IF_PC_2 !== e.pc2 || IF_HALT !== e.halt) begin
          n_fail++;
          $display("FAIL sb_data: got instr %h pc2 %h halt %b expected instr %h pc2 %h halt %b",
                   IF_instr, IF_PC_2, IF_HALT, e.instr, e.pc2, e.halt);
        end
      end
    end
  end

  task automatic cyc_a(input logic ev, input logic [15:0] ei, input logic [15:0] ep);
    exp_t e;
    if (ev) begin
      e.instr = ei;
      e.pc2   = ep;
      e.halt  = (ei[15:11] == 5'b00000);
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("valid", {15'd0, IF_valid}, {15'd0, ev});
  endtask

  task automatic cyc_b();
    @(posedge clk);
    #1;
    m_auto = 1'b1; m_done = 1'b0; m_stall = 1'b0; m_data = 16'h0000;
    redirect = 1'b0; redirect_PC = 16'h0000; PC_stall = 1'b0;
  endtask

  task automatic cyc(input logic ev, input logic [15:0] ei, input logic [15:0] ep);
    cyc_a(ev, ei, ep);
    cyc_b();
  endtask

  initial begin
    rst = 1'b0;
    m_auto = 1'b1; m_done = 1'b0; m_stall = 1'b0; m_data = 16'h0000;
    redirect = 1'b0; redirect_PC = 16'h0000; PC_stall = 1'b0;
    @(posedge clk); #1;

    // Reset state
    cyc_a(1'b0, 16'h0, 16'h0);
    chk("rst_rd", {15'd0, imem_rd}, 16'd0);
    chk("rst_instr", IF_instr, 16'h0800);
    chk("rst_pc2", IF_PC_2, 16'h0002);
    chk("rst_halt", {15'd0, IF_HALT}, 16'd0);
    cyc_b();
    rst = 1'b1;

    // Hits, then a two-cycle PC stall at 0x0002
    cyc_a(1'b1, 16'h4001, 16'h0002);
    chk("first_addr", imem_addr, 16'h0000);
    cyc_b();
    PC_stall = 1'b1;
    cyc(1'b1, 16'h4002, 16'h0004);
    PC_stall = 1'b1;
    cyc_a(1'b1, 16'h4002, 16'h0004);
    chk("stall_addr", imem_addr, 16'h0002);
`ifdef FETCH_BUF_EN
    chk("stall_rd", {15'd0, imem_rd}, 16'd0);
`else
    chk("stall_rd", {15'd0, imem_rd}, 16'd1);
`endif
    cyc_b();
    cyc(1'b1, 16'h4002, 16'h0004);

    // Miss at 0x0004, done three cycles later
    for (int i = 0; i < 3; i++) begin
      m_auto = 1'b0; m_stall = 1'b1;
      cyc_a(1'b0, 16'h0, 16'h0);
      chk("miss_addr", imem_addr, 16'h0004);
      cyc_b();
    end
    m_auto = 1'b0; m_done = 1'b1; m_data = 16'h4003;
    cyc(1'b1, 16'h4003, 16'h0006);

    // 0x0800 is not a HALT; 0x0000 at 0x0008 is
    cyc(1'b1, 16'h0800, 16'h0008);
    cyc(1'b1, 16'h0000, 16'h000A);
    cyc_a(1'b0, 16'h0, 16'h0);
    chk("halted_rd", {15'd0, imem_rd}, 16'd0);
    chk("halted_instr", IF_instr, 16'h0800);
    chk("halted_halt", {15'd0, IF_HALT}, 16'd0);
    cyc_b();
    redirect = 1'b1; redirect_PC = 16'h0020;
    cyc(1'b0, 16'h0, 16'h0);
    cyc(1'b1, 16'h4020, 16'h0022);

    // Redirect during a miss, in-flight data 0xBEEF must be dropped
    m_auto = 1'b0; m_stall = 1'b1;
    cyc(1'b0, 16'h0, 16'h0);
    m_auto = 1'b0; m_stall = 1'b1; redirect = 1'b1; redirect_PC = 16'h0100;
    cyc(1'b0, 16'h0, 16'h0);
    m_auto = 1'b0; m_stall = 1'b1;
    cyc_a(1'b0, 16'h0, 16'h0);
    chk("discard_rd", {15'd0, imem_rd}, 16'd0);
    cyc_b();
    m_auto = 1'b0; m_done = 1'b1; m_data = 16'hBEEF;
    cyc(1'b0, 16'h0, 16'h0);
    cyc(1'b1, 16'h4100, 16'h0102);

    // Redirect in FETCH to 0xFFFE, then wrap
    redirect = 1'b1; redirect_PC = 16'hFFFE;
    cyc(1'b0, 16'h0, 16'h0);
    cyc_a(1'b1, 16'h4FFE, 16'h0000);
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    cyc_b();
    cyc_a(1'b1, 16'h4001, 16'h0002);
    chk("wrap_addr1", imem_addr, 16'h0000);
    cyc_b();

    // imem_done together with redirect in MISS goes to FETCH
    m_auto = 1'b0; m_stall = 1'b1;
    cyc(1'b0, 16'h0, 16'h0);
    m_auto = 1'b0; m_done = 1'b1; m_data = 16'hBEEF; redirect = 1'b1; redirect_PC = 16'h0004;
    cyc(1'b0, 16'h0, 16'h0);
    cyc_a(1'b1, 16'h4003, 16'h0006);
    chk("post_redir_rd", {15'd0, imem_rd}, 16'd1);
    cyc_b();

    // Reset asserted mid-miss
    m_auto = 1'b0; m_stall = 1'b1;
    cyc(1'b0, 16'h0, 16'h0);
    rst = 1'b0; m_auto = 1'b0; m_stall = 1'b1;
    cyc_a(1'b0, 16'h0, 16'h0);
    chk("midrst_rd", {15'd0, imem_rd}, 16'd0);
    chk("midrst_pc2", IF_PC_2, 16'h0002);
    chk("midrst_instr", IF_instr, 16'h0800);
    cyc_b();
    rst = 1'b1;
    cyc(1'b1, 16'h4001, 16'h0002);

    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
